path_listener_mt: RTL and testbench

PATH_LISTENER_MT -- requirements
Module: path_listener_mt

---
 rtl/listener_mt_pkg.sv | 27 ++
 rtl/listener_filter_tree.sv | 105 ++++++++++
 rtl/path_listener_mt.sv | 217 +++++++++++++++++++++
 tb/tb_path_listener_mt.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/listener_mt_pkg.sv
// Shared slot-state encoding and parameter defaults for the path listener.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package listener_mt_pkg;

    localparam int DEF_NUM_PORTS    = 64;
    localparam int DEF_GROUP        = 8;
    localparam int DEF_NUM_TARGETS  = 4;
    localparam int DEF_NUM_PATHS_DW = 16;
    localparam int DEF_NODE_DW      = 12;
    localparam int DEF_CNT_DW       = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_LEARN    = 3'd2,
        S_ACCUM    = 3'd3,
        S_DONE     = 3'd4,
        S_REPORTED = 3'd5
    } slot_state_t;

    // A slot only listens for request hits while it is still collecting.
    function automatic logic slot_listening(input slot_state_t s);
        return (s == S_ARMED) || (s == S_LEARN) || (s == S_ACCUM);
    endfunction

endpackage

// File: rtl/listener_filter_tree.sv
// Two-stage lowest-index match selector for one target slot across all request ports.
// Latency: 2 cycles from request inputs to hit_vld/hit_paths.
// Backpressure: none; flush drops every hit in flight for this slot.
module listener_filter_tree
    import listener_mt_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int GROUP        = DEF_GROUP,
    parameter int NUM_PATHS_DW = DEF_NUM_PATHS_DW,
    parameter int NODE_DW      = DEF_NODE_DW
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             listen,
    input  logic [NODE_DW-1:0]               node,
    input  logic [NUM_PORTS-1:0]             req_vld,
    input  logic [NUM_PORTS*NUM_PATHS_DW-1:0] req_paths,
    input  logic [NUM_PORTS*NODE_DW-1:0]     req_nodenum,
    output logic                             hit_vld,
    output logic                             hit_multi,
    output logic [NUM_PATHS_DW-1:0]          hit_paths
);

    localparam int NG = NUM_PORTS / GROUP;

    logic [NUM_PORTS-1:0]    match;
    logic [NG-1:0]           s1_vld_c, s1_multi_c, s1_vld, s1_multi;
    logic [NUM_PATHS_DW-1:0] s1_paths_c [NG];
    logic [NUM_PATHS_DW-1:0] s1_paths   [NG];
    logic                    s2_vld_c, s2_multi_c;
    logic [NUM_PATHS_DW-1:0] s2_paths_c;

    // Per-port match against this slot's node, gated by the slot listening.
    always_comb begin
        match = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            match[p] = listen && req_vld[p] && (req_nodenum[p*NODE_DW +: NODE_DW] == node);
        end
    end

    // Stage 1: lowest-index match inside each group; note any second match.
    always_comb begin
        s1_vld_c   = '0;
        s1_multi_c = '0;
        for (int g = 0; g < NG; g++) begin
            s1_paths_c[g] = '0;
            for (int j = 0; j < GROUP; j++) begin
                if (match[g*GROUP + j]) begin
                    if (s1_vld_c[g]) begin
                        s1_multi_c[g] = 1'b1;
                    end else begin
                        s1_vld_c[g]   = 1'b1;
                        s1_paths_c[g] = req_paths[(g*GROUP + j)*NUM_PATHS_DW +: NUM_PATHS_DW];
                    end
                end
            end
        end
    end

    // Stage 1 register; flush kills the valids so a reconfigured slot sees no stale hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= '0;
            s1_multi <= '0;
            for (int g = 0; g < NG; g++) s1_paths[g] <= '0;
        end else begin
            s1_vld   <= flush ? '0 : s1_vld_c;
            s1_multi <= flush ? '0 : s1_multi_c;
            for (int g = 0; g < NG; g++) s1_paths[g] <= s1_paths_c[g];
        end
    end

    // Stage 2: lowest-index valid group; multiple groups or an in-group double is a collision.
    always_comb begin
        s2_vld_c   = 1'b0;
        s2_multi_c = 1'b0;
        s2_paths_c = '0;
        for (int g = 0; g < NG; g++) begin
            if (s1_vld[g]) begin
                if (s1_multi[g]) s2_multi_c = 1'b1;
                if (s2_vld_c) begin
                    s2_multi_c = 1'b1;
                end else begin
                    s2_vld_c   = 1'b1;
                    s2_paths_c = s1_paths[g];
                end
            end
        end
    end

    // Stage 2 register feeding the slot update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_vld   <= 1'b0;
            hit_multi <= 1'b0;
            hit_paths <= '0;
        end else begin
            hit_vld   <= flush ? 1'b0 : s2_vld_c;
            hit_multi <= flush ? 1'b0 : s2_multi_c;
            hit_paths <= s2_paths_c;
        end
    end

endmodule

// File: rtl/path_listener_mt.sv
// Multi-target path listener: learns expected arrivals per slot, then sums path counts (LISTENER_SAT_EN = saturating sum).
// Latency: 3 cycles request-to-slot-state; a finished slot is presented in the cycle its state becomes DONE.
// Backpressure: o_res_* held stable while o_res_vld & !i_res_rdy; accepted slot moves to REPORTED.
module path_listener_mt
    import listener_mt_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int GROUP        = DEF_GROUP,
    parameter int NUM_TARGETS  = DEF_NUM_TARGETS,
    parameter int NUM_PATHS_DW = DEF_NUM_PATHS_DW,
    parameter int NODE_DW      = DEF_NODE_DW,
    parameter int CNT_DW       = DEF_CNT_DW
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_cfg_we,
    input  logic [$clog2(NUM_TARGETS)-1:0]      i_cfg_idx,
    input  logic [NODE_DW-1:0]                  i_cfg_node,
    input  logic                                i_start_counting,
    input  logic [NUM_PORTS-1:0]                i_req_vld,
    input  logic [NUM_PORTS*NUM_PATHS_DW-1:0]   i_req_paths,
    input  logic [NUM_PORTS*NODE_DW-1:0]        i_req_nodenum,
    output logic                                o_res_vld,
    input  logic                                i_res_rdy,
    output logic [$clog2(NUM_TARGETS)-1:0]      o_res_idx,
    output logic [NUM_PATHS_DW-1:0]             o_res_paths,
    output logic                                o_res_ovf,
    output logic                                o_collision,
    output logic                                o_err,
    output logic                                o_all_done
);

    localparam int IDX_W = $clog2(NUM_TARGETS);

    slot_state_t             state   [NUM_TARGETS];
    slot_state_t             state_n [NUM_TARGETS];
    logic [NODE_DW-1:0]      node    [NUM_TARGETS];
    logic [NODE_DW-1:0]      node_n  [NUM_TARGETS];
    logic [CNT_DW-1:0]       cnt     [NUM_TARGETS];
    logic [CNT_DW-1:0]       cnt_n   [NUM_TARGETS];
    logic [NUM_PATHS_DW-1:0] acc     [NUM_TARGETS];
    logic [NUM_PATHS_DW-1:0] acc_n   [NUM_TARGETS];
`ifdef LISTENER_SAT_EN
    logic [NUM_TARGETS-1:0]  ovf, ovf_n;
`endif

    logic [NUM_TARGETS-1:0]  cfg_hit, listen, hit_vld, hit_multi;
    logic [NUM_PATHS_DW-1:0] hit_paths [NUM_TARGETS];
    logic                    phase_d1, phase_d2;
    logic                    err_n, coll_n;
    logic                    lock_vld, lock_vld_n;
    logic [IDX_W-1:0]        lock_idx, lock_idx_n;
    logic [IDX_W-1:0]        first_done, sel_idx;
    logic                    any_done, res_fire;
    logic                    any_used, all_rep;

    for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_slot
        assign cfg_hit[t] = i_cfg_we && (i_cfg_idx == IDX_W'(t));
        assign listen[t]  = slot_listening(state[t]);

        listener_filter_tree #(
            .NUM_PORTS   (NUM_PORTS),
            .GROUP       (GROUP),
            .NUM_PATHS_DW(NUM_PATHS_DW),
            .NODE_DW     (NODE_DW)
        ) u_tree (
            .clk        (clk),
            .rst        (rst),
            .flush      (cfg_hit[t]),
            .listen     (listen[t]),
            .node       (node[t]),
            .req_vld    (i_req_vld),
            .req_paths  (i_req_paths),
            .req_nodenum(i_req_nodenum),
            .hit_vld    (hit_vld[t]),
            .hit_multi  (hit_multi[t]),
            .hit_paths  (hit_paths[t])
        );
    end

    // Phase bit travels alongside the hits so each hit is applied in the phase it arrived in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_d1 <= 1'b0;
            phase_d2 <= 1'b0;
        end else begin
            phase_d1 <= i_start_counting;
            phase_d2 <= phase_d1;
        end
    end

    // Lowest-index DONE slot and the all-reported summary.
    always_comb begin
        first_done = '0;
        any_done   = 1'b0;
        any_used   = 1'b0;
        all_rep    = 1'b1;
        for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
            if (state[t] == S_DONE) begin
                any_done   = 1'b1;
                first_done = IDX_W'(t);
            end
            if (state[t] != S_IDLE) begin
                any_used = 1'b1;
                if (state[t] != S_REPORTED) all_rep = 1'b0;
            end
        end
    end

    // Once presented and stalled, the result index is locked so a lower slot finishing cannot swap it.
    assign sel_idx     = lock_vld ? lock_idx : first_done;
    assign o_res_vld   = lock_vld ? (state[lock_idx] == S_DONE) : any_done;
    assign o_res_idx   = o_res_vld ? sel_idx : '0;
    assign o_res_paths = o_res_vld ? acc[sel_idx] : '0;
    assign res_fire    = o_res_vld && i_res_rdy;
    assign o_all_done  = any_used && all_rep;
`ifdef LISTENER_SAT_EN
    assign o_res_ovf   = o_res_vld && ovf[sel_idx];
`else
    assign o_res_ovf   = 1'b0;
`endif

    // Slot next-state: config beats a same-edge hit; hits drive learn/accumulate; accept retires.
    always_comb begin
`ifdef LISTENER_SAT_EN
        logic [NUM_PATHS_DW:0] sum;
        sum   = '0;
        ovf_n = ovf;
`endif
        err_n      = o_err;
        coll_n     = o_collision;
        lock_vld_n = lock_vld;
        lock_idx_n = lock_idx;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            state_n[t] = state[t];
            node_n[t]  = node[t];
            cnt_n[t]   = cnt[t];
            acc_n[t]   = acc[t];
            if (hit_vld[t] && hit_multi[t]) coll_n = 1'b1;
            if (cfg_hit[t]) begin
                state_n[t] = S_ARMED;
                node_n[t]  = i_cfg_node;
                cnt_n[t]   = '0;
                acc_n[t]   = '0;
`ifdef LISTENER_SAT_EN
                ovf_n[t]   = 1'b0;
`endif
            end else if (hit_vld[t] && slot_listening(state[t])) begin
                if (!phase_d2) begin
                    if (&cnt[t]) err_n = 1'b1;
                    else         cnt_n[t] = cnt[t] + CNT_DW'(1);
                    if (state[t] == S_ARMED) state_n[t] = S_LEARN;
                end else if (cnt[t] == '0) begin
                    err_n      = 1'b1;
                    state_n[t] = S_ACCUM;
                end else begin
                    cnt_n[t]   = cnt[t] - CNT_DW'(1);
                    state_n[t] = (cnt[t] == CNT_DW'(1)) ? S_DONE : S_ACCUM;
`ifdef LISTENER_SAT_EN
                    sum = {1'b0, acc[t]} + {1'b0, hit_paths[t]};
                    if (sum[NUM_PATHS_DW]) begin
                        acc_n[t] = '1;
                        ovf_n[t] = 1'b1;
                    end else begin
                        acc_n[t] = sum[NUM_PATHS_DW-1:0];
                    end
`else
                    acc_n[t] = acc[t] + hit_paths[t];
`endif
                end
            end else if (res_fire && (sel_idx == IDX_W'(t))) begin
                state_n[t] = S_REPORTED;
            end
        end
        if (res_fire) begin
            lock_vld_n = 1'b0;
        end else if (o_res_vld && !lock_vld) begin
            lock_vld_n = 1'b1;
            lock_idx_n = sel_idx;
        end
        if (lock_vld_n && (state_n[lock_idx_n] != S_DONE)) lock_vld_n = 1'b0;
    end

    // Slot, sticky-flag and result-lock registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                state[t] <= S_IDLE;
                node[t]  <= '0;
                cnt[t]   <= '0;
                acc[t]   <= '0;
            end
`ifdef LISTENER_SAT_EN
            ovf         <= '0;
`endif
            o_err       <= 1'b0;
            o_collision <= 1'b0;
            lock_vld    <= 1'b0;
            lock_idx    <= '0;
        end else begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                state[t] <= state_n[t];
                node[t]  <= node_n[t];
                cnt[t]   <= cnt_n[t];
                acc[t]   <= acc_n[t];
            end
`ifdef LISTENER_SAT_EN
            ovf         <= ovf_n;
`endif
            o_err       <= err_n;
            o_collision <= coll_n;
            lock_vld    <= lock_vld_n;
            lock_idx    <= lock_idx_n;
        end
    end

endmodule

// File: tb/tb_path_listener_mt.sv
// Directed self-checking bench for path_listener_mt (8-bit paths, 2-bit counts, 64 ports, 4 slots).
// Latency: checks taken 1 time unit after the rising edge.
// Backpressure: i_res_rdy driven explicitly per scenario.
module tb_path_listener_mt;

    localparam int NP = 64;
    localparam int PW = 8;
    localparam int NW = 12;

    logic              clk;
    logic              rst;
    logic              i_cfg_we;
    logic [1:0]        i_cfg_idx;
    logic [NW-1:0]     i_cfg_node;
    logic              i_start_counting;
    logic [NP-1:0]     i_req_vld;
    logic [NP*PW-1:0]  i_req_paths;
    logic [NP*NW-1:0]  i_req_nodenum;
    logic              o_res_vld;
    logic              i_res_rdy;
    logic [1:0]        o_res_idx;
    logic [PW-1:0]     o_res_paths;
    logic              o_res_ovf;
    logic              o_collision;
    logic              o_err;
    logic              o_all_done;

    int n_chk  = 0;
    int n_pass = 0;
    int bad;

    path_listener_mt #(
        .NUM_PORTS(NP), .GROUP(8), .NUM_TARGETS(4),
        .NUM_PATHS_DW(PW), .NODE_DW(NW), .CNT_DW(2)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_node(i_cfg_node),
        .i_start_counting(i_start_counting),
        .i_req_vld(i_req_vld), .i_req_paths(i_req_paths), .i_req_nodenum(i_req_nodenum),
        .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_idx(o_res_idx),
        .o_res_paths(o_res_paths), .o_res_ovf(o_res_ovf),
        .o_collision(o_collision), .o_err(o_err), .o_all_done(o_all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        i_req_vld     = '0;
        i_req_paths   = '0;
        i_req_nodenum = '0;
    endtask

    task automatic set_port(input int p, input logic [NW-1:0] nd, input logic [PW-1:0] paths);
        i_req_vld[p]               = 1'b1;
        i_req_paths[p*PW +: PW]    = paths;
        i_req_nodenum[p*NW +: NW]  = nd;
    endtask

    // Present the staged requests for exactly one edge.
    task automatic pulse();
        tick(1);
        clear_req();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [NW-1:0] nd);
        i_cfg_we   = 1'b1;
        i_cfg_idx  = idx;
        i_cfg_node = nd;
        tick(1);
        i_cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_req();
        i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_node = '0;
        i_start_counting = 1'b0;
        i_res_rdy = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_vld", 32'(o_res_vld), 0);
        chk("rst_paths", 32'(o_res_paths), 0);
        chk("rst_flags", {29'd0, o_collision, o_err, o_all_done}, 0);

        // Learn three, accumulate 5+7+9 on slot 0
        cfg(2'd0, 12'h123);
        for (int i = 0; i < 3; i++) begin set_port(5, 12'h123, 8'd0); pulse(); end
        i_start_counting = 1'b1;
        set_port(10, 12'h123, 8'd5); pulse();
        set_port(20, 12'h123, 8'd7); pulse();
        set_port(63, 12'h123, 8'd9); pulse();
        tick(1);
        chk("acc_not_yet", 32'(o_res_vld), 0);
        tick(1);
        chk("acc_vld", 32'(o_res_vld), 1);
        chk("acc_idx", 32'(o_res_idx), 0);
        chk("acc_paths", 32'(o_res_paths), 21);
        chk("acc_err", 32'(o_err), 0);
        i_res_rdy = 1'b1; tick(1); i_res_rdy = 1'b0;
        chk("acc_all_done", 32'(o_all_done), 1);
        chk("acc_vld_after", 32'(o_res_vld), 0);

        // Two slots finish together; stall then accept one at a time
        do_reset();
        cfg(2'd0, 12'h010);
        cfg(2'd1, 12'h020);
        set_port(0, 12'h010, 8'd0); set_port(1, 12'h020, 8'd0); pulse();
        i_start_counting = 1'b1;
        set_port(2, 12'h010, 8'd11); set_port(9, 12'h020, 8'd22); pulse();
        tick(2);
        chk("hs_idx0", 32'(o_res_idx), 0);
        chk("hs_paths0", 32'(o_res_paths), 11);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (o_res_vld !== 1'b1 || o_res_idx !== 2'd0 || o_res_paths !== 8'd11) bad++;
        end
        chk("hs_hold_bad_cycles", 32'(bad), 0);
        i_res_rdy = 1'b1; tick(1); i_res_rdy = 1'b0;
        chk("hs_vld1", 32'(o_res_vld), 1);
        chk("hs_idx1", 32'(o_res_idx), 1);
        chk("hs_paths1", 32'(o_res_paths), 22);
        chk("hs_not_all_done", 32'(o_all_done), 0);
        i_res_rdy = 1'b1; tick(1); i_res_rdy = 1'b0;
        chk("hs_all_done", 32'(o_all_done), 1);

        // Collision: ports 3 and 40 hit slot 1 together
        do_reset();
        cfg(2'd1, 12'h055);
        set_port(0, 12'h055, 8'd0); pulse();
        i_start_counting = 1'b1;
        tick(2);
        chk("col_before", 32'(o_collision), 0);
        set_port(3, 12'h055, 8'd30); set_port(40, 12'h055, 8'd70); pulse();
        tick(2);
        chk("col_flag", 32'(o_collision), 1);
        chk("col_idx", 32'(o_res_idx), 1);
        chk("col_paths", 32'(o_res_paths), 30);

        // 200 + 100 on 8-bit accumulator
        do_reset();
        cfg(2'd2, 12'h0AA);
        for (int i = 0; i < 2; i++) begin set_port(7, 12'h0AA, 8'd0); pulse(); end
        i_start_counting = 1'b1;
        set_port(7, 12'h0AA, 8'd200); pulse();
        set_port(7, 12'h0AA, 8'd100); pulse();
        tick(2);
        chk("sat_vld", 32'(o_res_vld), 1);
`ifdef LISTENER_SAT_EN
        chk("sat_paths", 32'(o_res_paths), 255);
        chk("sat_ovf", 32'(o_res_ovf), 1);
`else
        chk("wrap_paths", 32'(o_res_paths), 44);
        chk("wrap_ovf", 32'(o_res_ovf), 0);
`endif

        // Learn counter overflow: fourth learn at all-ones flags error and holds 3
        do_reset();
        cfg(2'd3, 12'h777);
        for (int i = 0; i < 3; i++) begin set_port(30, 12'h777, 8'd0); pulse(); end
        tick(2);
        chk("lovf_no_err", 32'(o_err), 0);
        set_port(30, 12'h777, 8'd0); pulse();
        tick(2);
        chk("lovf_err", 32'(o_err), 1);
        i_start_counting = 1'b1;
        for (int i = 0; i < 3; i++) begin set_port(31, 12'h777, 8'd1); pulse(); end
        tick(2);
        chk("lovf_idx", 32'(o_res_idx), 3);
        chk("lovf_paths", 32'(o_res_paths), 3);

        // Reset during accumulate with a hit in flight
        do_reset();
        cfg(2'd0, 12'h300);
        cfg(2'd1, 12'h301);
        set_port(0, 12'h300, 8'd0); set_port(16, 12'h301, 8'd0); set_port(17, 12'h301, 8'd0); pulse();
        set_port(0, 12'h300, 8'd0); pulse();
        i_start_counting = 1'b1;
        set_port(0, 12'h300, 8'd4); set_port(16, 12'h301, 8'd6); pulse();
        tick(2);
        chk("mid_vld_pre", 32'(o_res_vld), 1);
        chk("mid_col_pre", 32'(o_collision), 1);
        set_port(0, 12'h300, 8'd1); pulse();
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {25'd0, o_res_vld, o_res_idx, o_res_ovf, o_collision, o_err, o_all_done}, 0);
        chk("mid_rst_paths", 32'(o_res_paths), 0);
        #2 rst = 1'b0;
        tick(3);
        chk("mid_inflight_gone", 32'(o_res_vld), 0);
        set_port(0, 12'h000, 8'd1); pulse();
        tick(2);
        chk("mid_idle_ignored", {30'd0, o_err, o_res_vld}, 0);

        // Config write on the same edge as a learn hit: hit dropped, count stays 0
        do_reset();
        cfg(2'd0, 12'h0F0);
        set_port(1, 12'h0F0, 8'd0); pulse();
        tick(1);
        cfg(2'd0, 12'h0F0);
        i_start_counting = 1'b1;
        set_port(1, 12'h0F0, 8'd50); pulse();
        tick(2);
        chk("race_err", 32'(o_err), 1);
        chk("race_no_result", 32'(o_res_vld), 0);
        i_start_counting = 1'b0;
        set_port(1, 12'h0F0, 8'd0); pulse();
        i_start_counting = 1'b1;
        set_port(1, 12'h0F0, 8'd9); pulse();
        tick(2);
        chk("zero_acc_vld", 32'(o_res_vld), 1);
        chk("zero_acc_paths", 32'(o_res_paths), 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
